// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//   Resolves conditional branches in EX and owns the direct-mapped branch
//   history table (BHT) of 2-bit saturating counters that IF reads for its
//   taken/not-taken prediction. A misprediction raises a registered,
//   one-cycle redirect to fetch.
//
//   Optional feature macro: BRANCH_PERF_CNT_EN. When it is defined, the
//   saturating counters perf_branches and perf_mispredicts are added.
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   if_pc             fetch PC for the BHT lookup
//   pred_taken        combinational prediction (counter MSB) for if_pc
//   ex_*              EX-stage branch inputs (valid, type, operands, pc, imm,
//                     carried prediction, flush)
//   takebranch        combinational resolved outcome
//   mispredict        registered one-cycle pulse
//   redirect_pc       registered correct next PC, valid while mispredict=1
//   perf_branches     (BRANCH_PERF_CNT_EN) resolved-branch count
//   perf_mispredicts  (BRANCH_PERF_CNT_EN) mispredict-pulse count
module branch_resolve_unit #(
   parameter int         XLEN        = 32,
   parameter int         BHT_ENTRIES = 64,
   parameter logic [1:0] CTR_INIT    = 2'b01
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] if_pc,
   output logic            pred_taken,
   input  logic            ex_valid,
   input  logic            ex_is_branch,
   input  logic [2:0]      ex_funct3,
   input  logic [XLEN-1:0] ex_opA,
   input  logic [XLEN-1:0] ex_opB,
   input  logic [XLEN-1:0] ex_pc,
   input  logic [XLEN-1:0] ex_imm,
   input  logic            ex_pred_taken,
   input  logic            ex_flush,
   output logic            takebranch,
   output logic            mispredict,
   output logic [XLEN-1:0] redirect_pc
`ifdef BRANCH_PERF_CNT_EN
   ,
   output logic [31:0]     perf_branches,
   output logic [31:0]     perf_mispredicts
`endif
);

   localparam int IW = $clog2(BHT_ENTRIES);

   logic [1:0]      bht [BHT_ENTRIES];
   logic [IW-1:0]   if_idx, ex_idx;
   logic            legal, cond, resolved, mis_now;
   logic [1:0]      ctr_cur, ctr_next;
   logic [XLEN-1:0] target, fall_thru;

   // Only the index bits of the fetch PC feed the lookup.
   logic unused_if_pc;
   assign unused_if_pc = ^{if_pc[XLEN-1:IW+2], if_pc[1:0]};

   assign if_idx = if_pc[IW+1:2];
   assign ex_idx = ex_pc[IW+1:2];

   // Lookup reads the array directly: a same-cycle update to the same index
   // is not bypassed, so IF sees the pre-update counter.
   assign pred_taken = bht[if_idx][1];

   always_comb begin
      legal = 1'b1;
      cond  = 1'b0;
      case (ex_funct3)
         3'b000:  cond = (ex_opA == ex_opB);
         3'b001:  cond = (ex_opA != ex_opB);
         3'b100:  cond = ($signed(ex_opA) <  $signed(ex_opB));
         3'b101:  cond = ($signed(ex_opA) >= $signed(ex_opB));
         3'b110:  cond = (ex_opA <  ex_opB);
         3'b111:  cond = (ex_opA >= ex_opB);
         default: legal = 1'b0;   // 010/011 behave as non-branches
      endcase
   end

   assign resolved   = ex_valid & ex_is_branch & ~ex_flush & legal;
   assign takebranch = resolved & cond;
   assign mis_now    = resolved & (takebranch != ex_pred_taken);

   // Both adds wrap modulo 2^XLEN.
   assign target    = ex_pc + ex_imm;
   assign fall_thru = ex_pc + XLEN'(4);

   assign ctr_cur = bht[ex_idx];

   always_comb begin
      ctr_next = ctr_cur;
      if (takebranch) begin
         if (ctr_cur != 2'b11) ctr_next = ctr_cur + 2'd1;
      end else begin
         if (ctr_cur != 2'b00) ctr_next = ctr_cur - 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= CTR_INIT;
         mispredict  <= 1'b0;
         redirect_pc <= '0;
      end else begin
         if (resolved) bht[ex_idx] <= ctr_next;
         mispredict <= mis_now;
         if (mis_now) redirect_pc <= takebranch ? target : fall_thru;
      end
   end

`ifdef BRANCH_PERF_CNT_EN
   // Counting mis_now in a non-reset cycle matches the pulses emitted.
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_branches    <= '0;
         perf_mispredicts <= '0;
      end else begin
         if (resolved && perf_branches != 32'hFFFF_FFFF)
            perf_branches <= perf_branches + 32'd1;
         if (mis_now && perf_mispredicts != 32'hFFFF_FFFF)
            perf_mispredicts <= perf_mispredicts + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit. Directed vectors carry
// hand-computed expectations; expected redirects are queued at issue and
// a negedge monitor pops one on every mispredict pulse.
module tb_branch_resolve_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] if_pc;
   logic        pred_taken;
   logic        ex_valid, ex_is_branch, ex_pred_taken, ex_flush;
   logic [2:0]  ex_funct3;
   logic [31:0] ex_opA, ex_opB, ex_pc, ex_imm;
   logic        takebranch, mispredict;
   logic [31:0] redirect_pc;
`ifdef BRANCH_PERF_CNT_EN
   logic [31:0] perf_branches, perf_mispredicts;
`endif

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_q [$];

   always #5 clk = ~clk;

   branch_resolve_unit dut (
      .clk(clk), .reset(reset), .if_pc(if_pc), .pred_taken(pred_taken),
      .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_funct3(ex_funct3),
      .ex_opA(ex_opA), .ex_opB(ex_opB), .ex_pc(ex_pc), .ex_imm(ex_imm),
      .ex_pred_taken(ex_pred_taken), .ex_flush(ex_flush),
      .takebranch(takebranch), .mispredict(mispredict), .redirect_pc(redirect_pc)
`ifdef BRANCH_PERF_CNT_EN
      , .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
`endif
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: every mispredict pulse must match the oldest queued redirect.
   always @(negedge clk) begin
      if (mispredict === 1'b1) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_mispredict got=%h want=none", redirect_pc);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if (redirect_pc !== e) begin
               bad++;
               $display("FAIL redirect_pc got=%h want=%h", redirect_pc, e);
            end
         end
      end
   end

   // One EX cycle; if_pc points at the branch's own index so the pred check
   // also covers the same-cycle read/write collision (pre-update value).
   task automatic br(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] pc, input logic [31:0] imm, input logic pr,
                     input logic fl, input logic v, input logic ep, input logic et,
                     input logic em, input logic [31:0] erd);
      @(posedge clk); #1;
      ex_valid = v; ex_is_branch = 1'b1; ex_funct3 = f3; ex_opA = a; ex_opB = b;
      ex_pc = pc; ex_imm = imm; ex_pred_taken = pr; ex_flush = fl; if_pc = pc;
      if (em) exp_q.push_back(erd);
      #1;
      chk("pred_taken", {31'd0, pred_taken}, {31'd0, ep});
      chk("takebranch", {31'd0, takebranch}, {31'd0, et});
   endtask

   task automatic chk_pred(input logic [31:0] pc, input logic ep);
      @(posedge clk); #1;
      ex_valid = 1'b0; ex_is_branch = 1'b0; ex_flush = 1'b0; if_pc = pc;
      #1 chk("pred_lookup", {31'd0, pred_taken}, {31'd0, ep});
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; if_pc = '0; ex_valid = 0; ex_is_branch = 0; ex_funct3 = 0;
      ex_opA = 0; ex_opB = 0; ex_pc = 0; ex_imm = 0; ex_pred_taken = 0; ex_flush = 0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      chk("rst_mispredict", {31'd0, mispredict}, 32'd0);
      chk("rst_redirect", redirect_pc, 32'd0);
`ifdef BRANCH_PERF_CNT_EN
      chk("rst_perf_br", perf_branches, 32'd0);
      chk("rst_perf_mis", perf_mispredicts, 32'd0);
`endif
      for (int i = 0; i < 64; i++) begin
         if_pc = i * 4;
         #1 chk("rst_pred", {31'd0, pred_taken}, 32'd0);
      end

      //  f3      opA           opB    pc            imm           pr fl v  ep et em  redirect
      br(3'b000, 32'd5,        32'd5, 32'h100,      32'h20,       0, 0, 1, 0, 1, 1, 32'h120);
      chk_pred(32'h100, 1'b1);                       // counter 01 -> 10
      br(3'b100, 32'hFFFF_FFFF, 32'd1, 32'h304,     32'h8,        1, 0, 1, 0, 1, 0, 32'h0);
      br(3'b110, 32'hFFFF_FFFF, 32'd1, 32'h308,     32'h8,        0, 0, 1, 0, 0, 0, 32'h0);
      br(3'b001, 32'd3,        32'd3, 32'h200,      32'h40,       1, 0, 1, 1, 0, 1, 32'h204);
      // back-to-back mispredicts, signed vs unsigned GE, negative offset
      br(3'b101, 32'hFFFF_FFFF, 32'd1, 32'h310,     32'h40,       1, 0, 1, 0, 0, 1, 32'h314);
      br(3'b111, 32'hFFFF_FFFF, 32'd1, 32'h314,     32'hFFFF_FFF0, 0, 0, 1, 0, 1, 1, 32'h304);
      // target and fall-through wrap around
      br(3'b000, 32'd7,        32'd7, 32'hFFFF_FFFC, 32'h8,       0, 0, 1, 0, 1, 1, 32'h4);
      br(3'b001, 32'd7,        32'd7, 32'hFFFF_FFFC, 32'h8,       1, 0, 1, 1, 0, 1, 32'h0);

      // saturation at index 16: 01 -> 10 -> 11 -> 11 -> 11 -> 11
      br(3'b000, 32'd1, 32'd1, 32'h40, 32'h10, 1, 0, 1, 0, 1, 0, 32'h0);
      for (int i = 0; i < 4; i++)
         br(3'b000, 32'd1, 32'd1, 32'h40, 32'h10, 1, 0, 1, 1, 1, 0, 32'h0);
      // 11 -> 10 -> 01 -> 00 -> 00 -> 00
      br(3'b001, 32'd1, 32'd1, 32'h40, 32'h10, 0, 0, 1, 1, 0, 0, 32'h0);
      br(3'b001, 32'd1, 32'd1, 32'h40, 32'h10, 0, 0, 1, 1, 0, 0, 32'h0);
      br(3'b001, 32'd1, 32'd1, 32'h40, 32'h10, 0, 0, 1, 0, 0, 0, 32'h0);
      br(3'b001, 32'd1, 32'd1, 32'h40, 32'h10, 0, 0, 1, 0, 0, 0, 32'h0);
      br(3'b001, 32'd1, 32'd1, 32'h40, 32'h10, 0, 0, 1, 0, 0, 0, 32'h0);
      // 00 -> 01 still predicts not-taken
      br(3'b000, 32'd1, 32'd1, 32'h40, 32'h10, 0, 0, 1, 0, 1, 1, 32'h50);
      chk_pred(32'h40, 1'b0);

      // squashed / illegal / invalid: no resolution, no mispredict, no update
      br(3'b000, 32'd1, 32'd1, 32'h80, 32'h10, 0, 1, 1, 0, 0, 0, 32'h0);
      chk_pred(32'h80, 1'b0);
      br(3'b010, 32'd1, 32'd1, 32'h84, 32'h10, 1, 0, 1, 0, 0, 0, 32'h0);
      br(3'b011, 32'd1, 32'd1, 32'h88, 32'h10, 0, 0, 1, 0, 0, 0, 32'h0);
      br(3'b000, 32'd1, 32'd1, 32'h8C, 32'h10, 0, 0, 0, 0, 0, 0, 32'h0);
      chk_pred(32'h8C, 1'b0);

      // reset colliding with a mispredicting branch at an index holding 10
      br(3'b000, 32'd1, 32'd1, 32'hC0, 32'h10, 1, 0, 1, 0, 1, 0, 32'h0);
      chk_pred(32'hC0, 1'b1);
      br(3'b000, 32'd1, 32'd1, 32'hC0, 32'h10, 0, 0, 1, 1, 1, 0, 32'h0);
      reset = 1'b1;                                  // same cycle as the branch
      @(posedge clk); #1;
      reset = 1'b0; ex_valid = 1'b0; ex_is_branch = 1'b0;
      #1;
      chk("rst_coll_mispredict", {31'd0, mispredict}, 32'd0);
      chk("rst_coll_redirect", redirect_pc, 32'd0);
      chk_pred(32'hC0, 1'b0);
      chk_pred(32'h304, 1'b0);

      // three resolved branches, one mispredict
      br(3'b000, 32'd2, 32'd2, 32'h400, 32'h10, 1, 0, 1, 0, 1, 0, 32'h0);
      br(3'b001, 32'd2, 32'd2, 32'h404, 32'h10, 0, 0, 1, 0, 0, 0, 32'h0);
      br(3'b110, 32'd1, 32'd2, 32'h408, 32'h10, 0, 0, 1, 0, 1, 1, 32'h418);
      chk_pred(32'h400, 1'b1);
`ifdef BRANCH_PERF_CNT_EN
      chk("perf_branches", perf_branches, 32'd3);
      chk("perf_mispredicts", perf_mispredicts, 32'd1);
`endif
      repeat (3) @(posedge clk);
      chk("queue_drained", exp_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
